// File: rtl/sar_search_ctrl_if.sv
// Handshake and comparator bundle for the successive-approximation search controller.
// The master side starts a search and returns comparator flags; the slave side is the controller.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int STEPW = 3
);
    logic             start;
    logic             y_e;
    logic             y_g;
    logic             y_l;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [STEPW-1:0] steps;
    logic             err;

    modport master (
        output start, y_e, y_g, y_l,
        input  b, busy, done, result, steps, err
    );

    modport slave (
        input  start, y_e, y_g, y_l,
        output b, busy, done, result, steps, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation controller: binary-searches the comparator's a operand MSB first,
// exiting early on equality and flagging any trial whose comparator flags are not one-hot.
module sar_search_ctrl #(
    parameter int WIDTH = 4,
    parameter int STEPW = 3
) (
    input logic              clk,
    input logic              rst_n,
    sar_search_ctrl_if.slave bus
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH - 1);
    localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIAL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [IDXW-1:0]  r_idx;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [STEPW-1:0] r_steps;
    logic             r_err;

    logic             w_flags_ok;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_probe;

    function automatic logic is_one_hot3(input logic e, input logic g, input logic l);
        return (e & ~g & ~l) | (~e & g & ~l) | (~e & ~g & l);
    endfunction

    assign w_flags_ok = is_one_hot3(bus.y_e, bus.y_g, bus.y_l);
    assign w_acc_next = bus.y_g ? r_b : r_acc;
    // Next trial bit sits one position below the bit just resolved.
    assign w_probe    = ONE << (r_idx - IDXW'(1));

    // Search FSM: one trial per clock in TRIAL, one-cycle done pulse in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_b      <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_steps  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_TRIAL;
                        r_b     <= MSB;
                        r_acc   <= '0;
                        r_idx   <= IDX_TOP;
                        r_steps <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_TRIAL: begin
                    r_steps <= r_steps + STEPW'(1);
                    if (!w_flags_ok || bus.y_e || (r_idx == '0)) begin
                        // Any terminating trial: choose the result, then pulse done.
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_b     <= '0;
                        if (!w_flags_ok) begin
                            r_err    <= 1'b1;
                            r_result <= r_acc;
                        end else if (bus.y_e) begin
                            r_result <= r_b;
                        end else begin
                            r_result <= w_acc_next;
                        end
                    end else begin
                        r_acc <= w_acc_next;
                        r_idx <= r_idx - IDXW'(1);
                        r_b   <= w_acc_next | w_probe;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_b     <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.b      = r_b;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.steps  = r_steps;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Randomized self-checking bench for sar_search_ctrl with a behavioural comparator and
// an arithmetic reference for trial values, trial counts and latency.
module tb_sar_search_ctrl;
    localparam int WIDTH = 4;
    localparam int STEPW = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic             force_bad = 1'b0;
    int               n_checks = 0;
    int               n_errors = 0;

    always #5 clk = ~clk;

    sar_search_ctrl_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

    // Behavioural comparator; force_bad drives an illegal y_g=y_l=1 pattern.
    assign bus.y_e = force_bad ? 1'b0 : (a == bus.b);
    assign bus.y_g = force_bad ? 1'b1 : (a > bus.b);
    assign bus.y_l = force_bad ? 1'b1 : (a < bus.b);

    sar_search_ctrl #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Trials used: the search stops when the probe equals a, i.e. after the lowest set bit.
    function automatic int ref_steps(input int av);
        int tz;
        if (av == 0) return WIDTH;
        tz = 0;
        while (((av >> tz) & 1) == 0) tz++;
        return WIDTH - tz;
    endfunction

    // Trial j keeps a's bits above position WIDTH-j and sets bit WIDTH-j.
    function automatic int ref_trial(input int av, input int j);
        int hi;
        hi = WIDTH - j;
        return ((av >> (hi + 1)) << (hi + 1)) | (1 << hi);
    endfunction

    task automatic run_search(input int av, input int bad, input bit wobble);
        int  n;
        int  exp_k;
        int  exp_res;
        bit  exp_err;
        bit  done_seen;
        exp_k   = ref_steps(av);
        exp_res = av;
        exp_err = 1'b0;
        if (bad > 0 && bad <= exp_k) begin
            exp_k   = bad;
            exp_res = (av >> (WIDTH - bad + 1)) << (WIDTH - bad + 1);
            exp_err = 1'b1;
        end
        @(negedge clk);
        a         = WIDTH'(av);
        bus.start = 1'b1;
        n         = 0;
        done_seen = 1'b0;
        while (n < 2 * WIDTH + 2 && !done_seen) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            force_bad = 1'b0;
            if (bus.done) begin
                done_seen = 1'b1;
            end else begin
                check_eq("busy_in_trial", int'(bus.busy), 1);
                if (n == 1) check_eq("err_cleared", int'(bus.err), 0);
                if (!wobble) check_eq("b_trial", int'(bus.b), ref_trial(av, n));
                if (bad == n) force_bad = 1'b1;
                if (wobble) a = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            end
        end
        check_eq("done_seen", int'(done_seen), 1);
        check_eq("busy_at_done", int'(bus.busy), 0);
        check_eq("b_at_done", int'(bus.b), 0);
        if (wobble) begin
            check_eq("latency_bound", int'(n <= WIDTH + 1), 1);
            check_eq("err_wobble", int'(bus.err), 0);
        end else begin
            check_eq("latency", n, exp_k + 1);
            check_eq("result", int'(bus.result), exp_res);
            check_eq("steps", int'(bus.steps), exp_k);
            check_eq("err", int'(bus.err), int'(exp_err));
        end
        @(negedge clk);
        check_eq("done_one_cycle", int'(bus.done), 0);
        if (!wobble) check_eq("result_hold", int'(bus.result), exp_res);
    endtask

    initial begin
        int pulses;
        bus.start = 1'b0;
        #1;
        check_eq("rst_b", int'(bus.b), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.done), 0);
        check_eq("rst_result", int'(bus.result), 0);
        check_eq("rst_steps", int'(bus.steps), 0);
        check_eq("rst_err", int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the plan.
        run_search(11, 0, 1'b0);
        run_search(8, 0, 1'b0);
        run_search(0, 0, 1'b0);
        run_search(15, 0, 1'b0);
        run_search(11, 2, 1'b0);
        run_search(11, 0, 1'b0);

        // Reset after two trials must clear everything at once.
        @(negedge clk);
        a         = 4'd11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_b", int'(bus.b), 0);
        check_eq("mid_rst_busy", int'(bus.busy), 0);
        check_eq("mid_rst_done", int'(bus.done), 0);
        check_eq("mid_rst_result", int'(bus.result), 0);
        check_eq("mid_rst_steps", int'(bus.steps), 0);
        check_eq("mid_rst_err", int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_search(6, 0, 1'b0);

        // Start held high: a=5 takes 4 trials, so done repeats every 6 edges.
        @(negedge clk);
        a         = 4'd5;
        bus.start = 1'b1;
        pulses    = 0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            check_eq("bb_done_timing", int'(bus.done), int'((n % 6) == 5));
            if (bus.done) begin
                pulses++;
                check_eq("bb_result", int'(bus.result), 5);
                check_eq("bb_steps", int'(bus.steps), 4);
            end
        end
        bus.start = 1'b0;
        check_eq("bb_pulses", pulses, 6);

        // Randomized operands with occasional flag faults and moving operands.
        for (int i = 0; i < 40; i++) begin
            int av;
            int bad;
            av  = int'($urandom_range(0, (1 << WIDTH) - 1));
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0;
            run_search(av, bad, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            run_search(int'($urandom_range(0, (1 << WIDTH) - 1)), 0, 1'b1);
        end

        // Exhaustive sweep of every operand value.
        for (int av = 0; av < (1 << WIDTH); av++) begin
            run_search(av, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Sequential successive-approximation controller wrapped around the team's combinational magnitude comparator (ports a, b, y_e, y_g, y_l).
- Drives the comparator's b input with trial values and consumes the y_e/y_g/y_l flags it returns.
- Finds the unknown value on the comparator's a input by binary search, MSB first, with early exit on equality.
- Reports the found value with a start/done handshake.

Parameters:
- WIDTH, 4, operand width; must match the comparator width.
- STEPW, 3, width of steps counter; must be at least clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin search; sampled only in IDLE.
- y_e  in  1  comparator flag a==b.
- y_g  in  1  comparator flag a>b.
- y_l  in  1  comparator flag a<b.
- b  out  WIDTH  trial value driven to the comparator b input; registered.
- busy  out  1  high while in TRIAL.
- done  out  1  one-cycle pulse when the search ends.
- result  out  WIDTH  found value; held from done until the next accepted start.
- steps  out  STEPW  number of trials used by the last search.
- err  out  1  sticky flag: flags were not one-hot during a trial.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, b=0, busy=0, done=0, result=0, steps=0, err=0.
- Reset mid-search aborts immediately and lands in IDLE with all reset values.
- All outputs are registered. Comparator flags are combinational from b, so each trial is evaluated one clock edge after b is updated.

States:
- IDLE:
  - start=1 at an edge gives: state=TRIAL, b=1<<(WIDTH-1), internal acc=0, idx=WIDTH-1, steps=0, err=0, busy=1.
  - result keeps its old value until done.
- TRIAL (one trial per cycle), at each edge:
  - steps += 1.
  - Flags not exactly one-hot: err=1, result=acc, go DONE.
  - y_e=1: result=b, go DONE (early exit).
  - y_g=1: acc=b. y_l=1: acc unchanged.
  - idx==0: result=new acc, go DONE.
  - Otherwise: idx -= 1, b = new acc | (1<<(idx-1)).
- DONE:
  - done=1, busy=0, b=0 for exactly one cycle; then IDLE.
  - start asserted during DONE is ignored.

Latency and rules:
- start edge to done high is k+1 edges, where k = trials used, 1..WIDTH.
- Only y_e terminates early; y_g on the last bit still ends the search at WIDTH trials.
- start while busy or done is ignored and does not restart the search.
- Back-to-back: start may be accepted on the first IDLE cycle after done.
- If a changes mid-search, the result is undefined but the FSM must still terminate within WIDTH trials.
- result always equals a when the flags are consistent, including a=0 and a=2^WIDTH-1.
- b never exceeds WIDTH bits; no wrap occurs because idx stops at 0.

Test Plan:
- a=4'b1011, pulse start -> b sequence 1000,1100,1010,1011; flags g,l,g,e; done on the 5th edge; result=1011, steps=4, err=0.
- a=4'b1000 -> one trial (y_e on 1000); done on the 2nd edge; result=1000, steps=1.
- a=0 -> trials 1000,0100,0010,0001, all l; result=0000, steps=4. Separately a=15 -> 1000,1100,1110,1111; result=1111, steps=4.
- Force y_g=y_l=1 on the second trial -> err=1, done pulses, result=1000. The next start clears err.
- Assert rst_n=0 mid-search after 2 trials -> all outputs 0 immediately. After release, start with a=6 -> result=0110.
- Hold start high continuously with a=5 -> searches run back-to-back; start is ignored during TRIAL/DONE; each search gives result=0101 with one done pulse per search.
- Exhaustive sweep a=0..15 against the real comparator -> result==a, err=0 every search.
